// File: rtl/mul_mdc_package.sv
// Shared types and default widths for the mul_mdc tile sequencer and its address generator.
package mul_mdc_package;

   localparam int MUL_MDC_ADDR_W = 32;
   localparam int MUL_MDC_TILE_W = 16;
   localparam int MUL_MDC_N_SRC  = 2;

   typedef enum logic [2:0] {
      TS_IDLE,
      TS_ISSUE,
      TS_RUN,
      TS_NEXT,
      TS_DONE
   } tile_seq_state_t;

   typedef struct packed {
      logic                                    start;
      logic [MUL_MDC_TILE_W-1:0]               nb_tiles;
      logic [MUL_MDC_N_SRC*MUL_MDC_ADDR_W-1:0] base_src;
      logic [MUL_MDC_ADDR_W-1:0]               base_snk;
      logic [MUL_MDC_ADDR_W-1:0]               stride;
      logic [MUL_MDC_ADDR_W-1:0]               size;
   } ctrl_tile_seq_t;

   typedef struct packed {
      logic                      busy;
      logic                      done;
      logic [MUL_MDC_TILE_W-1:0] tile_idx;
   } flags_tile_seq_t;

endpackage

// File: rtl/mul_mdc_tile_addr_gen.sv
// Per-stream tile address registers, tile counter and last-tile detection.
module mul_mdc_tile_addr_gen
   import mul_mdc_package::*;
#(
   parameter int ADDR_W = MUL_MDC_ADDR_W,
   parameter int TILE_W = MUL_MDC_TILE_W,
   parameter int N_SRC  = MUL_MDC_N_SRC
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    load_i,
   input  logic                    inc_i,
   input  logic [TILE_W-1:0]       nb_tiles_i,
   input  logic [N_SRC*ADDR_W-1:0] base_src_i,
   input  logic [ADDR_W-1:0]       base_snk_i,
   input  logic [ADDR_W-1:0]       stride_i,
   output logic [N_SRC*ADDR_W-1:0] src_addr_o,
   output logic [ADDR_W-1:0]       snk_addr_o,
   output logic [TILE_W-1:0]       tile_idx_o,
   output logic                    last_o
);

   logic [N_SRC*ADDR_W-1:0] src_addr_q, src_addr_d;
   logic [ADDR_W-1:0]       snk_addr_q, snk_addr_d;
   logic [ADDR_W-1:0]       stride_q, stride_d;
   logic [TILE_W-1:0]       nb_tiles_q, nb_tiles_d;
   logic [TILE_W-1:0]       tile_idx_q, tile_idx_d;

   always_comb begin
      src_addr_d = src_addr_q;
      snk_addr_d = snk_addr_q;
      stride_d   = stride_q;
      nb_tiles_d = nb_tiles_q;
      tile_idx_d = tile_idx_q;
      if (load_i) begin
         src_addr_d = base_src_i;
         snk_addr_d = base_snk_i;
         stride_d   = stride_i;
         nb_tiles_d = nb_tiles_i;
         tile_idx_d = '0;
      end else if (inc_i) begin
         // Address arithmetic wraps modulo 2^ADDR_W by construction.
         for (int i = 0; i < N_SRC; i++) begin
            src_addr_d[i*ADDR_W +: ADDR_W] = src_addr_q[i*ADDR_W +: ADDR_W] + stride_q;
         end
         snk_addr_d = snk_addr_q + stride_q;
         tile_idx_d = tile_idx_q + TILE_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         src_addr_q <= '0;
         snk_addr_q <= '0;
         stride_q   <= '0;
         nb_tiles_q <= '0;
         tile_idx_q <= '0;
      end else begin
         src_addr_q <= src_addr_d;
         snk_addr_q <= snk_addr_d;
         stride_q   <= stride_d;
         nb_tiles_q <= nb_tiles_d;
         tile_idx_q <= tile_idx_d;
      end
   end

   assign src_addr_o = src_addr_q;
   assign snk_addr_o = snk_addr_q;
   assign tile_idx_o = tile_idx_q;
   assign last_o     = (tile_idx_q + TILE_W'(1)) == nb_tiles_q;

endmodule

// File: rtl/mul_mdc_tile_sequencer.sv
// Tile scheduler: issues streamer requests per tile, starts the engine and
// collects all completions before stepping addresses to the next tile.
module mul_mdc_tile_sequencer
   import mul_mdc_package::*;
#(
   parameter int ADDR_W = MUL_MDC_ADDR_W,
   parameter int TILE_W = MUL_MDC_TILE_W,
   parameter int N_SRC  = MUL_MDC_N_SRC
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    clear_i,
   input  logic                    start_i,
   input  logic [TILE_W-1:0]       nb_tiles_i,
   input  logic [N_SRC*ADDR_W-1:0] base_src_i,
   input  logic [ADDR_W-1:0]       base_snk_i,
   input  logic [ADDR_W-1:0]       tile_stride_i,
   input  logic [ADDR_W-1:0]       trans_size_i,
   output logic [N_SRC-1:0]        src_req_o,
   output logic [N_SRC*ADDR_W-1:0] src_addr_o,
   input  logic [N_SRC-1:0]        src_ack_i,
   input  logic [N_SRC-1:0]        src_done_i,
   output logic                    snk_req_o,
   output logic [ADDR_W-1:0]       snk_addr_o,
   input  logic                    snk_ack_i,
   input  logic                    snk_done_i,
   output logic [ADDR_W-1:0]       size_o,
   output logic                    eng_start_o,
   input  logic                    eng_done_i,
   output logic [TILE_W-1:0]       tile_idx_o,
   output logic                    busy_o,
   output logic                    done_o
);

   tile_seq_state_t   state_q, state_d;
   logic [N_SRC-1:0]  src_ack_q, src_ack_d, src_done_q, src_done_d;
   logic              snk_ack_q, snk_ack_d, snk_done_q, snk_done_d;
   logic              eng_done_q, eng_done_d;
   logic [ADDR_W-1:0] size_q, size_d;
   logic [N_SRC-1:0]  src_ack_now, src_done_now;
   logic              snk_ack_now, snk_done_now, eng_done_now;
   logic              acks_all, dones_all;
   logic              load, inc, last, rst_all;

   assign rst_all = rst_i | clear_i;

   mul_mdc_tile_addr_gen #(
      .ADDR_W(ADDR_W),
      .TILE_W(TILE_W),
      .N_SRC (N_SRC)
   ) u_addr_gen (
      .clk_i      (clk_i),
      .rst_i      (rst_all),
      .load_i     (load),
      .inc_i      (inc),
      .nb_tiles_i (nb_tiles_i),
      .base_src_i (base_src_i),
      .base_snk_i (base_snk_i),
      .stride_i   (tile_stride_i),
      .src_addr_o (src_addr_o),
      .snk_addr_o (snk_addr_o),
      .tile_idx_o (tile_idx_o),
      .last_o     (last)
   );

   // Sticky flags merged with this cycle's pulses so same-cycle events count.
   assign src_ack_now  = src_ack_q | src_ack_i;
   assign snk_ack_now  = snk_ack_q | snk_ack_i;
   assign src_done_now = src_done_q | src_done_i;
   assign snk_done_now = snk_done_q | snk_done_i;
   assign eng_done_now = eng_done_q | eng_done_i;
   assign acks_all     = (&src_ack_now) & snk_ack_now;
   assign dones_all    = (&src_done_now) & snk_done_now & eng_done_now;

   always_comb begin
      state_d     = state_q;
      src_ack_d   = src_ack_q;
      snk_ack_d   = snk_ack_q;
      src_done_d  = src_done_q;
      snk_done_d  = snk_done_q;
      eng_done_d  = eng_done_q;
      size_d      = size_q;
      load        = 1'b0;
      inc         = 1'b0;
      eng_start_o = 1'b0;
      unique case (state_q)
         TS_IDLE: begin
            if (start_i) begin
               load       = 1'b1;
               size_d     = trans_size_i;
               src_ack_d  = '0;
               snk_ack_d  = 1'b0;
               src_done_d = '0;
               snk_done_d = 1'b0;
               eng_done_d = 1'b0;
               state_d    = (nb_tiles_i == '0) ? TS_DONE : TS_ISSUE;
            end
         end
         TS_ISSUE: begin
            src_ack_d  = src_ack_now;
            snk_ack_d  = snk_ack_now;
            src_done_d = src_done_now;
            snk_done_d = snk_done_now;
            eng_done_d = eng_done_now;
            if (acks_all) begin
               eng_start_o = 1'b1;
               state_d     = TS_RUN;
            end
         end
         TS_RUN: begin
            src_done_d = src_done_now;
            snk_done_d = snk_done_now;
            eng_done_d = eng_done_now;
            if (dones_all) state_d = TS_NEXT;
         end
         TS_NEXT: begin
            src_ack_d  = '0;
            snk_ack_d  = 1'b0;
            src_done_d = '0;
            snk_done_d = 1'b0;
            eng_done_d = 1'b0;
            if (last) begin
               state_d = TS_DONE;
            end else begin
               inc     = 1'b1;
               state_d = TS_ISSUE;
            end
         end
         TS_DONE: state_d = TS_IDLE;
         default: state_d = TS_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_all) begin
         state_q    <= TS_IDLE;
         src_ack_q  <= '0;
         snk_ack_q  <= 1'b0;
         src_done_q <= '0;
         snk_done_q <= 1'b0;
         eng_done_q <= 1'b0;
         size_q     <= '0;
      end else begin
         state_q    <= state_d;
         src_ack_q  <= src_ack_d;
         snk_ack_q  <= snk_ack_d;
         src_done_q <= src_done_d;
         snk_done_q <= snk_done_d;
         eng_done_q <= eng_done_d;
         size_q     <= size_d;
      end
   end

   assign src_req_o = {N_SRC{state_q == TS_ISSUE}} & ~src_ack_q;
   assign snk_req_o = (state_q == TS_ISSUE) & ~snk_ack_q;
   assign size_o    = size_q;
   assign busy_o    = (state_q != TS_IDLE);
   assign done_o    = (state_q == TS_DONE);

endmodule

// File: tb/tb_mul_mdc_tile_sequencer.sv
// Directed self-checking bench for mul_mdc_tile_sequencer.
module tb_mul_mdc_tile_sequencer;

   logic        clk = 1'b0;
   logic        rst, clear, start;
   logic [15:0] nb_tiles;
   logic [63:0] base_src;
   logic [31:0] base_snk, stride, tsize;
   logic [1:0]  src_req, src_ack, src_done;
   logic [63:0] src_addr;
   logic        snk_req, snk_ack, snk_done;
   logic [31:0] snk_addr, size;
   logic        eng_start, eng_done, busy, done;
   logic [15:0] tile_idx;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mul_mdc_tile_sequencer dut (
      .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start),
      .nb_tiles_i(nb_tiles), .base_src_i(base_src), .base_snk_i(base_snk),
      .tile_stride_i(stride), .trans_size_i(tsize),
      .src_req_o(src_req), .src_addr_o(src_addr), .src_ack_i(src_ack), .src_done_i(src_done),
      .snk_req_o(snk_req), .snk_addr_o(snk_addr), .snk_ack_i(snk_ack), .snk_done_i(snk_done),
      .size_o(size), .eng_start_o(eng_start), .eng_done_i(eng_done),
      .tile_idx_o(tile_idx), .busy_o(busy), .done_o(done)
   );

   // ctl = {src_req[1], src_req[0], snk_req, eng_start, busy, done}
   wire [5:0]   ctl  = {src_req, snk_req, eng_start, busy, done};
   wire [143:0] data = {src_addr, snk_addr, tile_idx, size};

   task automatic idle_inputs();
      start = 0; src_ack = 0; src_done = 0; snk_ack = 0; snk_done = 0; eng_done = 0;
   endtask

   task automatic fast_inputs();
      src_ack = 2'b11; snk_ack = 1; src_done = 2'b11; snk_done = 1; eng_done = 1;
   endtask

   task automatic start_job(input logic [15:0] n, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] d, input logic [31:0] s, input logic [31:0] z);
      idle_inputs();
      nb_tiles = n; base_src = {b, a}; base_snk = d; stride = s; tsize = z; start = 1;
   endtask

   task automatic test_reset();
      rst = 1; clear = 0; idle_inputs();
      nb_tiles = 0; base_src = 0; base_snk = 0; stride = 0; tsize = 0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (ctl !== 6'b0 || data !== 144'b0) begin
         failures++;
         $display("FAIL reset_outputs ctl=%b data=%h required ctl=000000 data=0", ctl, data);
      end
      rst = 0;
      @(negedge clk);
   endtask

   task automatic test_single_tile();
      start_job(1, 32'h1000, 32'h2000, 32'h3000, 32'h40, 32'h100);
      #1; checks++;
      if (ctl !== 6'b000000) begin failures++; $display("FAIL t1_c0_ctl got=%b want=000000", ctl); end
      @(negedge clk); idle_inputs(); fast_inputs(); #1;
      checks++;
      if (ctl !== 6'b111110) begin failures++; $display("FAIL t1_c1_ctl got=%b want=111110", ctl); end
      checks++;
      if (data !== {32'h2000, 32'h1000, 32'h3000, 16'd0, 32'h100}) begin
         failures++; $display("FAIL t1_c1_data got=%h want=%h", data, {32'h2000, 32'h1000, 32'h3000, 16'd0, 32'h100});
      end
      @(negedge clk); idle_inputs(); #1; checks++;
      if (ctl !== 6'b000010) begin failures++; $display("FAIL t1_c2_ctl got=%b want=000010", ctl); end
      @(negedge clk); #1; checks++;
      if (ctl !== 6'b000010) begin failures++; $display("FAIL t1_c3_ctl got=%b want=000010", ctl); end
      @(negedge clk); #1; checks++;
      if (ctl !== 6'b000011) begin failures++; $display("FAIL t1_c4_done got=%b want=000011", ctl); end
      checks++;
      if (data !== {32'h2000, 32'h1000, 32'h3000, 16'd0, 32'h100}) begin
         failures++; $display("FAIL t1_c4_addr_stable got=%h", data);
      end
      @(negedge clk); #1; checks++;
      if (ctl !== 6'b000000) begin failures++; $display("FAIL t1_c5_idle got=%b want=000000", ctl); end
   endtask

   task automatic test_delayed_acks();
      int phase, k, t, starts, dpulses;
      bit fin;
      logic [5:0]  e;
      logic [31:0] a2, d2;
      phase = 0; k = 0; t = 0; starts = 0; dpulses = 0; fin = 0; a2 = 0; d2 = 0;
      start_job(3, 32'h1000, 32'h2000, 32'h3000, 32'h40, 32'h80);
      @(negedge clk);
      for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
         idle_inputs();
         e = 6'b000010;
         case (phase)
            0: begin
               src_ack[0] = (k == 2); src_ack[1] = (k == 0); snk_ack = (k == 5);
               e = {k == 0, k <= 2, k <= 5, k == 5, 1'b1, 1'b0};
            end
            1: begin src_done = 2'b11; snk_done = 1; eng_done = 1; end
            3: e = 6'b000011;
            default: e = 6'b000010;
         endcase
         #1;
         checks++;
         if (ctl !== e) begin
            failures++; $display("FAIL t2_ctl tile=%0d phase=%0d k=%0d got=%b want=%b", t, phase, k, ctl, e);
         end
         if (phase == 0) begin
            checks++;
            if (data !== {32'h2000 + 32'(t) * 32'h40, 32'h1000 + 32'(t) * 32'h40,
                          32'h3000 + 32'(t) * 32'h40, 16'(t), 32'h80}) begin
               failures++; $display("FAIL t2_data tile=%0d got=%h", t, data);
            end
            if (t == 2) begin a2 = src_addr[31:0]; d2 = snk_addr; end
         end
         if (eng_start) starts++;
         if (done) dpulses++;
         case (phase)
            0: if (k == 5) phase = 1; else k++;
            1: phase = 2;
            2: begin t++; k = 0; phase = (t == 3) ? 3 : 0; end
            default: fin = 1;
         endcase
         @(negedge clk);
      end
      #1;
      checks++;
      if (!fin) begin failures++; $display("FAIL t2_timeout got=running want=finished"); end
      checks++;
      if (a2 !== 32'h1080 || d2 !== 32'h3080) begin
         failures++; $display("FAIL t2_tile2_addr got a=%h d=%h want a=00001080 d=00003080", a2, d2);
      end
      checks++;
      if (starts != 3 || dpulses != 1) begin
         failures++; $display("FAIL t2_pulses got starts=%0d done=%0d want 3 and 1", starts, dpulses);
      end
      checks++;
      if (ctl !== 6'b000000) begin failures++; $display("FAIL t2_idle got=%b want=000000", ctl); end
   endtask

   task automatic test_out_of_order_done();
      start_job(1, 32'h10, 32'h20, 32'h30, 32'h4, 32'h8);
      @(negedge clk); idle_inputs(); src_ack = 2'b11; src_done = 2'b01; #1;
      checks++;
      if (ctl !== 6'b111010) begin failures++; $display("FAIL t3_c1_ctl got=%b want=111010", ctl); end
      @(negedge clk); idle_inputs(); snk_ack = 1; #1;
      checks++;
      if (ctl !== 6'b001110) begin failures++; $display("FAIL t3_c2_ctl got=%b want=001110", ctl); end
      @(negedge clk); idle_inputs(); snk_done = 1; src_done = 2'b10; #1;
      @(negedge clk); idle_inputs(); #1;
      checks++;
      if (ctl !== 6'b000010) begin failures++; $display("FAIL t3_c4_run got=%b want=000010", ctl); end
      @(negedge clk); idle_inputs(); eng_done = 1; #1;
      @(negedge clk); idle_inputs(); #1;
      checks++;
      if (ctl !== 6'b000010) begin failures++; $display("FAIL t3_c6_next got=%b want=000010", ctl); end
      @(negedge clk); #1;
      checks++;
      if (ctl !== 6'b000011) begin failures++; $display("FAIL t3_c7_done got=%b want=000011", ctl); end
      @(negedge clk); #1;
   endtask

   task automatic test_zero_tiles();
      int n, first;
      bit req_seen;
      n = 0; first = 0; req_seen = 0;
      start_job(0, 32'h1000, 32'h2000, 32'h3000, 32'h40, 32'h8);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk); idle_inputs(); #1;
         if (src_req !== 2'b00 || snk_req !== 1'b0 || eng_start !== 1'b0) req_seen = 1;
         if (done === 1'b1) begin n++; if (first == 0) first = i; end
      end
      checks++;
      if (req_seen) begin failures++; $display("FAIL t4_no_request got=request_seen want=none"); end
      checks++;
      if (n != 1 || first < 1 || first > 2) begin
         failures++; $display("FAIL t4_done_pulse got count=%0d cycle=%0d want count=1 cycle<=2", n, first);
      end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL t4_idle got busy=%b want=0", busy); end
   endtask

   task automatic test_addr_wrap();
      start_job(2, 32'hFFFF_FFC0, 32'hFFFF_FFE0, 32'hFFFF_FFC0, 32'h40, 32'h10);
      @(negedge clk); idle_inputs(); fast_inputs(); #1;
      @(negedge clk); idle_inputs(); #1;
      @(negedge clk); #1;
      @(negedge clk); fast_inputs(); #1;
      checks++;
      if (data !== {32'h20, 32'h0, 32'h0, 16'd1, 32'h10}) begin
         failures++; $display("FAIL t5_wrap got=%h want=%h", data, {32'h20, 32'h0, 32'h0, 16'd1, 32'h10});
      end
      @(negedge clk); idle_inputs();
      @(negedge clk);
      @(negedge clk); #1;
      checks++;
      if (ctl !== 6'b000011) begin failures++; $display("FAIL t5_done got=%b want=000011", ctl); end
      @(negedge clk); #1;
   endtask

   task automatic test_reset_clear_midjob();
      start_job(2, 32'h100, 32'h200, 32'h300, 32'h10, 32'h20);
      @(negedge clk); idle_inputs(); src_ack = 2'b11; snk_ack = 1;
      @(negedge clk); idle_inputs(); rst = 1; #1;
      checks++;
      if (ctl !== 6'b000010) begin failures++; $display("FAIL t6_run_before_rst got=%b want=000010", ctl); end
      @(negedge clk); rst = 0; #1;
      checks++;
      if (ctl !== 6'b0 || data !== 144'b0) begin
         failures++; $display("FAIL t6_rst_in_run ctl=%b data=%h required all zero", ctl, data);
      end
      start_job(2, 32'h100, 32'h200, 32'h300, 32'h10, 32'h20);
      @(negedge clk); idle_inputs(); #1;
      checks++;
      if (ctl !== 6'b111010) begin failures++; $display("FAIL t6_issue got=%b want=111010", ctl); end
      clear = 1;
      @(negedge clk); clear = 0; #1;
      checks++;
      if (ctl !== 6'b0 || data !== 144'b0) begin
         failures++; $display("FAIL t6_clear_in_issue ctl=%b data=%h required all zero", ctl, data);
      end
   endtask

   task automatic test_back_to_back();
      start_job(2, 32'h100, 32'h200, 32'h300, 32'h10, 32'h20);
      @(negedge clk); idle_inputs(); fast_inputs();
      @(negedge clk); idle_inputs();
      start = 1; nb_tiles = 5; base_src = {32'hAAAA_0000, 32'hBBBB_0000};
      base_snk = 32'hCCCC_0000; stride = 32'h999; tsize = 32'h777;
      @(negedge clk); idle_inputs(); #1;
      checks++;
      if (size !== 32'h20) begin failures++; $display("FAIL t7_size_kept got=%h want=00000020", size); end
      @(negedge clk); fast_inputs(); #1;
      checks++;
      if (data !== {32'h210, 32'h110, 32'h310, 16'd1, 32'h20}) begin
         failures++; $display("FAIL t7_tile1_data got=%h want=%h", data, {32'h210, 32'h110, 32'h310, 16'd1, 32'h20});
      end
      @(negedge clk); idle_inputs();
      @(negedge clk);
      @(negedge clk); #1;
      checks++;
      if (ctl !== 6'b000011) begin failures++; $display("FAIL t7_done got=%b want=000011", ctl); end
      @(negedge clk); #1;
      checks++;
      if (ctl !== 6'b000000) begin failures++; $display("FAIL t7_idle got=%b want=000000", ctl); end
   endtask

   initial begin
      test_reset();
      test_single_tile();
      test_delayed_acks();
      test_out_of_order_done();
      test_zero_tiles();
      test_addr_wrap();
      test_reset_clear_midjob();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
